mac_vec: RTL

MAC_VEC -- requirements
Module: mac_vec

---
 rtl/nn_pkg.sv | 19 +
 rtl/mac_vec_if.sv | 50 +++++
 rtl/mac_lane.sv | 37 +++
 rtl/mac_vec.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and constants for the vector MAC datapath.
// Holds the controller state encoding and accumulator sizing helper.
package nn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } mac_state_e;

    // One guard bit above the result width catches any overflow of a single add.
    localparam int SAT_GUARD = 1;

    function automatic int acc_width(input int out_w);
        return out_w + SAT_GUARD;
    endfunction

endpackage

// File: rtl/mac_vec_if.sv
// Job, operand-beat and result handshake bundle for mac_vec.
// master drives jobs and operands; slave is the MAC engine.
interface mac_vec_if #(
    parameter int IN_WIDTH   = 8,
    parameter int LANES      = 4,
    parameter int OUT_WIDTH  = 22,
    parameter int KLEN_WIDTH = 8
);

    logic                        start;
    logic [KLEN_WIDTH-1:0]       klen;
    logic                        signed_mode;
    logic                        in_valid;
    logic                        in_ready;
    logic [LANES*IN_WIDTH-1:0]   img_in;
    logic [LANES*IN_WIDTH-1:0]   weight_in;
    logic                        out_valid;
    logic                        out_ready;
    logic [OUT_WIDTH-1:0]        mac_out;
    logic                        sat_flag;

    modport master (
        output start,
        output klen,
        output signed_mode,
        output in_valid,
        output img_in,
        output weight_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  mac_out,
        input  sat_flag
    );

    modport slave (
        input  start,
        input  klen,
        input  signed_mode,
        input  in_valid,
        input  img_in,
        input  weight_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output mac_out,
        output sat_flag
    );

endinterface

// File: rtl/mac_lane.sv
// Single-lane registered multiplier, signed or unsigned per mode.
// Operands are widened to the product width so one multiplier serves both modes.
module mac_lane #(
    parameter int IN_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_mem,
    input  logic                  en,
    input  logic                  signed_mode,
    input  logic [IN_WIDTH-1:0]   a,
    input  logic [IN_WIDTH-1:0]   b,
    output logic [2*IN_WIDTH-1:0] prod
);

    localparam int PW = 2 * IN_WIDTH;

    logic [PW-1:0] ax;
    logic [PW-1:0] bx;
    logic [PW-1:0] p;

    always_comb begin
        ax = {PW{signed_mode & a[IN_WIDTH-1]}};
        ax[IN_WIDTH-1:0] = a;
        bx = {PW{signed_mode & b[IN_WIDTH-1]}};
        bx[IN_WIDTH-1:0] = b;
        p = ax * bx;
    end

    always_ff @(posedge clk or posedge rst_mem) begin
        if (rst_mem) begin
            prod <= '0;
        end else if (en) begin
            prod <= p;
        end
    end

endmodule

// File: rtl/mac_vec.sv
// Vector dot-product engine: LANES multipliers, lane-sum stage and
// saturating accumulator under a four-state job controller.
module mac_vec
    import nn_pkg::*;
#(
    parameter int IN_WIDTH   = 8,
    parameter int LANES      = 4,
    parameter int OUT_WIDTH  = 22,
    parameter int KLEN_WIDTH = 8
) (
    input logic       clk,
    input logic       rst_mem,
    mac_vec_if.slave  bus
);

    localparam int LG = $clog2(LANES);
    localparam int PW = 2 * IN_WIDTH;
    localparam int SW = PW + LG;
    localparam int AW = acc_width(OUT_WIDTH);

    mac_state_e state;
    mac_state_e nstate;

    logic [KLEN_WIDTH-1:0] klen_q;
    logic [KLEN_WIDTH-1:0] cnt_q;
    logic                  sm_q;
    logic                  drain_q;
    logic                  v1_q;
    logic                  v2_q;
    logic [PW-1:0]         prod [LANES];
    logic [SW-1:0]         sum_c;
    logic [SW-1:0]         sum_q;
    logic [OUT_WIDTH-1:0]  acc_q;
    logic [OUT_WIDTH-1:0]  acc_d;
    logic                  sat_q;
    logic                  sat_d;
    logic                  accept;
    logic                  last_beat;
    logic                  take_start;
    logic                  in_ready;
    logic                  out_valid;

    assign accept     = bus.in_valid & in_ready;
    assign last_beat  = accept && (cnt_q + KLEN_WIDTH'(1) == klen_q);
    assign take_start = (state == IDLE) && bus.start;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        mac_lane #(
            .IN_WIDTH (IN_WIDTH)
        ) u_lane (
            .clk         (clk),
            .rst_mem     (rst_mem),
            .en          (accept),
            .signed_mode (sm_q),
            .a           (bus.img_in[l*IN_WIDTH +: IN_WIDTH]),
            .b           (bus.weight_in[l*IN_WIDTH +: IN_WIDTH]),
            .prod        (prod[l])
        );
    end

    always_comb begin
        logic [SW-1:0] ext;
        ext   = '0;
        sum_c = '0;
        for (int l = 0; l < LANES; l++) begin
            ext = {SW{sm_q & prod[l][PW-1]}};
            ext[PW-1:0] = prod[l];
            sum_c = sum_c + ext;
        end
    end

    // Add in AW bits, then clamp if the guard bits disagree with the result.
    always_comb begin
        logic [AW-1:0] sum_x;
        logic [AW-1:0] acc_x;
        logic [AW-1:0] tot;
        sum_x = {AW{sm_q & sum_q[SW-1]}};
        sum_x[SW-1:0] = sum_q;
        acc_x = {AW{sm_q & acc_q[OUT_WIDTH-1]}};
        acc_x[OUT_WIDTH-1:0] = acc_q;
        tot   = acc_x + sum_x;
        acc_d = tot[OUT_WIDTH-1:0];
        sat_d = 1'b0;
        if (!sm_q) begin
            if (|tot[AW-1:OUT_WIDTH]) begin
                acc_d = '1;
                sat_d = 1'b1;
            end
        end else if (tot[AW-1:OUT_WIDTH-1] !=
                     {(AW-OUT_WIDTH+1){tot[AW-1]}}) begin
            acc_d = {tot[AW-1], {(OUT_WIDTH-1){~tot[AW-1]}}};
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_mem) begin
        if (rst_mem) begin
            klen_q  <= '0;
            cnt_q   <= '0;
            sm_q    <= 1'b0;
            drain_q <= 1'b0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            sum_q   <= '0;
            acc_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            v1_q    <= accept;
            v2_q    <= v1_q;
            drain_q <= (state == DRAIN) ? ~drain_q : 1'b0;
            if (accept) begin
                cnt_q <= cnt_q + KLEN_WIDTH'(1);
            end
            if (v1_q) begin
                sum_q <= sum_c;
            end
            if (v2_q) begin
                acc_q <= acc_d;
                sat_q <= sat_q | sat_d;
            end
            if (take_start) begin
                klen_q <= bus.klen;
                sm_q   <= bus.signed_mode;
                cnt_q  <= '0;
                acc_q  <= '0;
                sat_q  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_mem) begin
        if (rst_mem) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    nstate = (bus.klen == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_beat) begin
                    nstate = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_q) begin
                    nstate = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    nstate = IDLE;
                end
            end
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (1'b1)
            (state == RUN):  in_ready  = 1'b1;
            (state == DONE): out_valid = 1'b1;
            default: ;
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.mac_out   = acc_q;
    assign bus.sat_flag  = sat_q & out_valid;

endmodule
